// File: rtl/step_sequencer.sv
// Recordable step sequencer: Schmitt-triggered clock/reset/record inputs, pitch CV, gate, step and end-of-cycle trigger.
// Optional one-pole pitch glide is compiled in with STEP_SEQUENCER_GLIDE_EN.
module step_sequencer #(
    parameter int W            = 16,
    parameter int STEPS        = 8,
    parameter int TRIG_SAMPLES = 48,
    parameter int GLIDE_SHIFT  = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_clk,
    input  logic signed [W-1:0] sample_in0,
    input  logic signed [W-1:0] sample_in1,
    input  logic signed [W-1:0] sample_in2,
    input  logic signed [W-1:0] sample_in3,
    output logic signed [W-1:0] sample_out0,
    output logic signed [W-1:0] sample_out1,
    output logic signed [W-1:0] sample_out2,
    output logic signed [W-1:0] sample_out3,
    input  logic [7:0]          jack
);
    localparam int SW = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int TW = $clog2(TRIG_SAMPLES + 1);
    localparam logic signed [W-1:0] HI_TH   = W'(4000);
    localparam logic signed [W-1:0] LO_TH   = W'(2000);
    localparam logic signed [W-1:0] FULL    = W'(20000);
    localparam logic [W-1:0]        STEP_CV = W'(2000);

    logic                strobe_q;
    logic                clk_s, rst_s, rec_s;
    logic [SW-1:0]       step;
    logic signed [W-1:0] mem [STEPS];
    logic [TW-1:0]       trig_cnt;

    logic                tick;
    logic                clk_n, rst_n, rec_n;
    logic                clk_edge, rst_edge, wrap, rec_now;
    logic [SW-1:0]       step_n;
    logic [TW-1:0]       trig_n;
    logic signed [W-1:0] target, pitch_n;
    logic [W-1:0]        step_w;
    logic                unused_jack;

    assign unused_jack = ^{jack[7:4], jack[2]};

    function automatic logic schmitt(input logic st, input logic signed [W-1:0] x,
                                     input logic patched);
        if (!patched)   return 1'b0;
        if (x > HI_TH)  return 1'b1;
        if (x < LO_TH)  return 1'b0;
        return st;
    endfunction

    always_comb begin
        tick     = sample_clk & ~strobe_q;
        clk_n    = schmitt(clk_s, sample_in0, jack[0]);
        rst_n    = schmitt(rst_s, sample_in1, jack[1]);
        rec_n    = schmitt(rec_s, sample_in3, jack[3]);
        clk_edge = clk_n & ~clk_s;
        rst_edge = rst_n & ~rst_s;
        wrap     = 1'b0;
        step_n   = step;
        // A reset edge swallows a coincident clock edge, so it can never wrap.
        if (rst_edge) begin
            step_n = '0;
        end else if (clk_edge) begin
            if (step == SW'(STEPS - 1)) begin
                step_n = '0;
                wrap   = 1'b1;
            end else begin
                step_n = step + 1'b1;
            end
        end
        rec_now = (clk_edge | rst_edge) & rec_n;
        target  = rec_now ? sample_in2 : mem[step_n];
        if (wrap)
            trig_n = TW'(TRIG_SAMPLES);
        else if (trig_cnt != '0)
            trig_n = trig_cnt - 1'b1;
        else
            trig_n = '0;
        step_w = W'(step_n);
    end

`ifdef STEP_SEQUENCER_GLIDE_EN
    logic signed [W:0] glide_diff, glide_sum;
    always_comb begin
        glide_diff = {target[W-1], target} - {sample_out0[W-1], sample_out0};
        glide_sum  = {sample_out0[W-1], sample_out0} + (glide_diff >>> GLIDE_SHIFT);
        pitch_n    = glide_sum[W-1:0];
    end
`else
    always_comb begin
        pitch_n = target;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            strobe_q    <= 1'b0;
            clk_s       <= 1'b0;
            rst_s       <= 1'b0;
            rec_s       <= 1'b0;
            step        <= '0;
            trig_cnt    <= '0;
            sample_out0 <= '0;
            sample_out1 <= '0;
            sample_out2 <= '0;
            sample_out3 <= '0;
            for (int i = 0; i < STEPS; i++) mem[i] <= '0;
        end else begin
            strobe_q <= sample_clk;
            if (tick) begin
                clk_s       <= clk_n;
                rst_s       <= rst_n;
                rec_s       <= rec_n;
                step        <= step_n;
                trig_cnt    <= trig_n;
                if (rec_now) mem[step_n] <= sample_in2;
                sample_out0 <= pitch_n;
                sample_out1 <= clk_n ? FULL : '0;
                sample_out2 <= step_w * STEP_CV;
                sample_out3 <= (trig_n != '0) ? FULL : '0;
            end
        end
    end
endmodule

// File: tb/tb_step_sequencer.sv
// Directed bench for step_sequencer: stimulus pushes hand-computed outputs, a monitor checks them after each tick.
module tb_step_sequencer;
    localparam int W  = 16;
    localparam int G  = 20000;
    localparam int EW = 4 * W + 4;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                sample_clk = 1'b0;
    logic signed [W-1:0] sample_in0 = '0, sample_in1 = '0, sample_in2 = '0, sample_in3 = '0;
    logic signed [W-1:0] sample_out0, sample_out1, sample_out2, sample_out3;
    logic [7:0]          jack = '0;
    logic                sc_prev = 1'b0;

    logic [EW-1:0] exp_q[$];
    string         name_q[$];
    int            checks = 0;
    int            errors = 0;

    step_sequencer dut (
        .clk(clk), .rst(rst), .sample_clk(sample_clk),
        .sample_in0(sample_in0), .sample_in1(sample_in1),
        .sample_in2(sample_in2), .sample_in3(sample_in3),
        .sample_out0(sample_out0), .sample_out1(sample_out1),
        .sample_out2(sample_out2), .sample_out3(sample_out3),
        .jack(jack)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) sc_prev <= rst ? 1'b0 : sample_clk;

    // driver tasks
    task automatic tick(input string nm, input int i0, input int i1, input int i2, input int i3,
                        input int e0, input int e1, input int e2, input int e3, input logic [3:0] m);
        @(negedge clk);
        sample_in0 = W'(i0);
        sample_in1 = W'(i1);
        sample_in2 = W'(i2);
        sample_in3 = W'(i3);
        exp_q.push_back({m, W'(e0), W'(e1), W'(e2), W'(e3)});
        name_q.push_back(nm);
        sample_clk = 1'b1;
        @(negedge clk);
        sample_clk = 1'b0;
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_direct(input string nm, input logic signed [W-1:0] got, input int want);
        checks++;
        if (got !== W'(want)) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, want);
        end
    endtask

    // scoreboard monitor
    initial begin
        logic [EW-1:0]       e;
        string               nm;
        logic signed [W-1:0] got [4];
        logic signed [W-1:0] want [4];
        forever begin
            @(posedge clk);
            if (!rst && sample_clk && !sc_prev) begin
                @(negedge clk);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_tick: got output with no expectation queued");
                end else begin
                    e  = exp_q.pop_front();
                    nm = name_q.pop_front();
                    got  = '{sample_out0, sample_out1, sample_out2, sample_out3};
                    want = '{e[4*W-1:3*W], e[3*W-1:2*W], e[2*W-1:W], e[W-1:0]};
                    for (int f = 0; f < 4; f++) begin
                        if (e[4*W+3-f]) begin
                            checks++;
                            if (got[f] !== want[f]) begin
                                errors++;
                                $display("FAIL %s out%0d: got %0d expected %0d", nm, f, got[f], want[f]);
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        #3_000_000;
        errors++;
        $display("FAIL timeout: got no completion expected finish within time limit");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // stimulus
    initial begin
        int e0;
        // reset with random inputs
        repeat (3) begin
            @(negedge clk);
            rst        = 1'b1;
            sample_clk = 1'($urandom_range(0, 1));
            sample_in0 = W'($urandom_range(0, 65535));
            sample_in1 = W'($urandom_range(0, 65535));
            sample_in2 = W'($urandom_range(0, 65535));
            sample_in3 = W'($urandom_range(0, 65535));
            jack       = 8'($urandom_range(0, 255));
        end
        @(negedge clk);
        check_direct("reset_out0", sample_out0, 0);
        check_direct("reset_out1", sample_out1, 0);
        check_direct("reset_out2", sample_out2, 0);
        check_direct("reset_out3", sample_out3, 0);
        rst = 1'b0;
        sample_clk = 1'b0;
        sample_in0 = '0; sample_in1 = '0; sample_in2 = '0; sample_in3 = '0;
        @(negedge clk);
        check_direct("post_reset_out0", sample_out0, 0);
        check_direct("post_reset_out2", sample_out2, 0);

        // memory is zero on every step
        jack = 8'h01;
        for (int k = 1; k <= 8; k++) begin
            tick("zero_mem_hi", 8000, 0, 0, 0, 0, G, (k % 8) * 2000, (k == 8) ? G : 0, 4'b1111);
            tick("zero_mem_lo", 0, 0, 0, 0, 0, 0, (k % 8) * 2000, (k == 8) ? G : 0, 4'b1111);
        end
        pulse_rst();

        // record 1000*k into each step
        jack = 8'h0F;
        for (int k = 1; k <= 8; k++) begin
            tick("record_hi", 8000, 0, 1000 * k, 8000, 1000 * k, G, (k % 8) * 2000, (k == 8) ? G : 0, 4'b1111);
            tick("record_lo", 0, 0, 1000 * k, 8000, 1000 * k, 0, (k % 8) * 2000, (k == 8) ? G : 0, 4'b1111);
        end
        // playback with record off
        for (int k = 1; k <= 9; k++) begin
            e0 = ((k % 8) == 0) ? 8000 : 1000 * (k % 8);
            tick("play_hi", 8000, 0, 0, 0, e0, G, (k % 8) * 2000, 0, 4'b1110);
            tick("play_lo", 0, 0, 0, 0, e0, 0, (k % 8) * 2000, 0, 4'b1110);
        end

        // hysteresis on the clock input, starting at step 1
        tick("hyst_3000", 3000, 0, 0, 0, 1000, 0, 2000, 0, 4'b1110);
        tick("hyst_1500", 1500, 0, 0, 0, 1000, 0, 2000, 0, 4'b1110);
        tick("hyst_4500", 4500, 0, 0, 0, 2000, G, 4000, 0, 4'b1110);
        tick("hyst_3000b", 3000, 0, 0, 0, 2000, G, 4000, 0, 4'b1110);
        tick("hyst_2500", 2500, 0, 0, 0, 2000, G, 4000, 0, 4'b1110);
        tick("hyst_1999", 1999, 0, 0, 0, 2000, 0, 4000, 0, 4'b1110);
        pulse_rst();

        // wrap trigger lasts exactly 48 ticks
        for (int k = 1; k <= 8; k++) begin
            tick("wrap_hi", 8000, 0, 0, 0, 0, G, (k % 8) * 2000, (k == 8) ? G : 0, 4'b1111);
            tick("wrap_lo", 0, 0, 0, 0, 0, 0, (k % 8) * 2000, (k == 8) ? G : 0, 4'b1111);
        end
        for (int i = 1; i <= 46; i++)
            tick("trig_hold", 0, 0, 0, 0, 0, 0, 0, G, 4'b1111);
        tick("trig_end", 0, 0, 0, 0, 0, 0, 0, 0, 4'b1111);

        // reset edge at step 5 returns to 0 without a trigger
        for (int k = 1; k <= 5; k++) begin
            tick("to5_hi", 8000, 0, 0, 0, 0, G, k * 2000, 0, 4'b1111);
            tick("to5_lo", 0, 0, 0, 0, 0, 0, k * 2000, 0, 4'b1111);
        end
        tick("reset_edge", 0, 8000, 0, 0, 0, 0, 0, 0, 4'b1111);
        tick("reset_edge_lo", 0, 0, 0, 0, 0, 0, 0, 0, 4'b1111);

        // simultaneous reset and clock edges while recording
        tick("both_edges", 8000, 8000, -4000, 8000, -4000, G, 0, 0, 4'b1111);
        tick("both_edges_hold", 0, 0, 0, 0, -4000, 0, 0, 0, 4'b1111);
        tick("after_both", 8000, 0, 0, 0, 0, G, 2000, 0, 4'b1111);
        tick("after_both_lo", 0, 0, 0, 0, 0, 0, 2000, 0, 4'b1111);

        repeat (4) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
